// File: rtl/prbs_randomizer_par_pkg.sv
// Shared constants, FSM state type and the bit-serial LFSR reference step
// for the parallel WiMAX randomizer.
package prbs_pkg;

  localparam int                DEF_LFSR_LEN = 15;
  localparam logic [14:0]       DEF_TAPS     = 15'b000_0000_0000_0011;
  localparam logic [14:0]       DEF_SEED     = 15'b011_011_100_010_101;

  // Widest LFSR / beat the step function can unroll.
  localparam int MAX_LEN = 64;
  localparam int MAX_W   = 64;

  typedef enum logic {IDLE, ACTIVE} rnd_state_t;

  typedef struct packed {
    logic [MAX_LEN-1:0] state;
    logic [MAX_W-1:0]   data;
  } step_t;

  // Advances a len-bit Fibonacci LFSR n times; keystream bit k XORs
  // data[n-1-k], so the beat is consumed MSB first.
  function automatic step_t lfsr_step_n(input logic [MAX_LEN-1:0] state,
                                        input logic [MAX_LEN-1:0] taps,
                                        input logic [MAX_W-1:0]   data,
                                        input int                 len,
                                        input int                 n);
    step_t      r;
    logic       fb;
    logic [5:0] idx;
    logic [5:0] top;
    r.state = state;
    r.data  = data;
    top     = 6'(len - 1);
    for (int k = 0; k < MAX_W; k++) begin
      if (k < n) begin
        fb          = ^(r.state & taps);
        idx         = 6'(n - 1 - k);
        r.data[idx] = data[idx] ^ fb;
        r.state     = r.state >> 1;
        r.state[top] = fb;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_randomizer_par_if.sv
// Beat-stream interface: input side from the burst formatter, output side
// towards the FEC encoder.
interface prbs_randomizer_par_if #(
  parameter int DATA_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_first;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_first, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/prbs_randomizer_par_lfsr_unroll.sv
// Purely combinational DATA_W-step unrolled LFSR: next state plus
// randomized beat for a given starting state.
module lfsr_unroll
  import prbs_pkg::*;
#(
  parameter int                  LFSR_LEN = DEF_LFSR_LEN,
  parameter logic [LFSR_LEN-1:0] TAPS     = DEF_TAPS,
  parameter int                  DATA_W   = 8
) (
  input  logic [LFSR_LEN-1:0] state,
  input  logic [DATA_W-1:0]   data,
  output logic [LFSR_LEN-1:0] next_state,
  output logic [DATA_W-1:0]   out_data
);

  typedef logic [MAX_LEN-1:0] wide_state_t;
  typedef logic [MAX_W-1:0]   wide_data_t;

  step_t step;
  logic  unused_hi;

  always_comb begin
    step = lfsr_step_n(wide_state_t'(state), wide_state_t'(TAPS),
                       wide_data_t'(data), LFSR_LEN, DATA_W);
  end

  assign next_state = step.state[LFSR_LEN-1:0];
  assign out_data   = step.data[DATA_W-1:0];

  // Upper bits of the wide result are always zero / pass-through.
  assign unused_hi  = ^(step.state >> LFSR_LEN) ^ ^(step.data >> DATA_W);

endmodule

// File: rtl/prbs_randomizer_par.sv
// Frame-aware parallel LFSR randomizer with registered output stage,
// bypass mode and burst-protocol error reporting.
module prbs_randomizer_par
  import prbs_pkg::*;
#(
  parameter int                  LFSR_LEN = DEF_LFSR_LEN,
  parameter logic [LFSR_LEN-1:0] TAPS     = DEF_TAPS,
  parameter logic [LFSR_LEN-1:0] SEED     = DEF_SEED,
  parameter int                  DATA_W   = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [LFSR_LEN-1:0] cfg_seed,
  input  logic                cfg_bypass,
  prbs_randomizer_par_if.slave bus,
  output logic                err_no_last,
  output logic [15:0]         drop_cnt
);

  rnd_state_t          fsm;
  logic [LFSR_LEN-1:0] lfsr;
  logic [LFSR_LEN-1:0] base_state;
  logic [LFSR_LEN-1:0] step_state;
  logic [DATA_W-1:0]   step_data;
  logic                accept;
  logic                drop;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drop         = (fsm == IDLE) && !bus.in_first;

  // A first beat is keyed from cfg_seed itself, not from the running state.
  assign base_state   = bus.in_first ? cfg_seed : lfsr;

  lfsr_unroll #(
    .LFSR_LEN (LFSR_LEN),
    .TAPS     (TAPS),
    .DATA_W   (DATA_W)
  ) u_unroll (
    .state      (base_state),
    .data       (bus.in_data),
    .next_state (step_state),
    .out_data   (step_data)
  );

  // NOTE: every register below uses <= so all of them sample pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm           <= IDLE;
      lfsr          <= SEED;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      err_no_last   <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      if (bus.out_ready) bus.out_valid <= 1'b0;
      if (accept) begin
        if (drop) begin
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end else begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= cfg_bypass ? bus.in_data : step_data;
          bus.out_last  <= bus.in_last;
          lfsr          <= cfg_bypass ? base_state : step_state;
          fsm           <= bus.in_last ? IDLE : ACTIVE;
          if (fsm == ACTIVE && bus.in_first) err_no_last <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs_randomizer_par.sv
// Directed bench for prbs_randomizer_par: hand-derived vectors plus a
// keystream built from the recurrence x[k+15] = x[k] ^ x[k+1].
module tb_prbs_randomizer_par;

  localparam logic [14:0] SEED_V = 15'b011_011_100_010_101;

  logic        clock = 1'b0;
  logic        reset;
  logic [14:0] cfg_seed;
  logic        cfg_bypass;
  logic        err_no_last;
  logic [15:0] drop_cnt;

  int n_pass  = 0;
  int n_total = 0;

  prbs_randomizer_par_if #(.DATA_W(8)) bus ();

  prbs_randomizer_par #(
    .LFSR_LEN (15),
    .TAPS     (15'h0003),
    .SEED     (SEED_V),
    .DATA_W   (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_seed    (cfg_seed),
    .cfg_bypass  (cfg_bypass),
    .bus         (bus),
    .err_no_last (err_no_last),
    .drop_cnt    (drop_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Keystream byte for beat number `beat` after seeding with `seed`.
  function automatic logic [7:0] ks_byte(input logic [14:0] seed, input int beat);
    logic       x [0:127];
    logic [7:0] b;
    for (int i = 0; i < 128; i++) begin
      if (i < 15) x[i] = seed[i];
      else        x[i] = x[i-15] ^ x[i-14];
    end
    for (int k = 0; k < 8; k++) b[7-k] = x[8*beat+k] ^ x[8*beat+k+1];
    return b;
  endfunction

  task automatic drive(input logic [7:0] d, input logic f, input logic l, input logic b);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_first = f;
    bus.in_last  = l;
    cfg_bypass   = b;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    cfg_bypass   = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cfg_seed = SEED_V;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b1;
    idle();
    #12;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.out_data); else n_pass++;
    n_total++; if (bus.out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", bus.out_last); else n_pass++;
    n_total++; if (err_no_last !== 1'b0) $display("FAIL reset_err: got %b want 0", err_no_last); else n_pass++;
    n_total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.in_ready); else n_pass++;
    #1 reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    cfg_seed = SEED_V;
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    step();
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_b0_valid: got %b want 1", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data !== 8'hF9) $display("FAIL basic_b0_data: got %h want f9", bus.out_data); else n_pass++;
    n_total++; if (bus.out_last !== 1'b0) $display("FAIL basic_b0_last: got %b want 0", bus.out_last); else n_pass++;
    drive(8'h00, 1'b0, 1'b1, 1'b0);
    step();
    n_total++; if (bus.out_data !== 8'h36) $display("FAIL basic_b1_data: got %h want 36", bus.out_data); else n_pass++;
    n_total++; if (bus.out_last !== 1'b1) $display("FAIL basic_b1_last: got %b want 1", bus.out_last); else n_pass++;
    idle();
    step();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_reseed();
    logic [7:0]  d [3];
    logic [7:0]  exp_d;
    logic [14:0] seed;
    int          last_seen;
    d[0] = 8'hA5; d[1] = 8'h3C; d[2] = 8'h0F;
    seed = 15'h1234;
    cfg_seed = seed;
    last_seen = 0;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 3; j++) begin
        drive(d[j], j == 0, j == 2, 1'b0);
        step();
        exp_d = d[j] ^ ks_byte(seed, j);
        n_total++; if (bus.out_data !== exp_d) $display("FAIL reseed_r%0d_b%0d: got %h want %h", r, j, bus.out_data, exp_d); else n_pass++;
        if (bus.out_valid === 1'b1 && bus.out_last === 1'b1) last_seen++;
      end
      idle();
      step();
      n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reseed_gap_r%0d: got %b want 0", r, bus.out_valid); else n_pass++;
    end
    n_total++; if (last_seen !== 2) $display("FAIL reseed_last_count: got %0d want 2", last_seen); else n_pass++;
  endtask

  task automatic test_stall();
    logic [14:0] seed;
    logic [7:0]  e0, e1, e2;
    seed = 15'h5A5A;
    cfg_seed = seed;
    e0 = 8'h11 ^ ks_byte(seed, 0);
    e1 = 8'h22 ^ ks_byte(seed, 1);
    e2 = 8'h33 ^ ks_byte(seed, 2);
    drive(8'h11, 1'b1, 1'b0, 1'b0);
    step();
    n_total++; if (bus.out_data !== e0) $display("FAIL stall_b0: got %h want %h", bus.out_data, e0); else n_pass++;
    bus.out_ready = 1'b0;
    drive(8'h22, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step();
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL stall_ready_c%0d: got %b want 0", c, bus.in_ready); else n_pass++;
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_data !== e0) $display("FAIL stall_hold_c%0d: got %b/%h want 1/%h", c, bus.out_valid, bus.out_data, e0); else n_pass++;
    end
    bus.out_ready = 1'b1;
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL stall_release: got %b want 1", bus.in_ready); else n_pass++;
    step();
    n_total++; if (bus.out_data !== e1) $display("FAIL stall_b1: got %h want %h", bus.out_data, e1); else n_pass++;
    drive(8'h33, 1'b0, 1'b1, 1'b0);
    step();
    n_total++; if (bus.out_data !== e2 || bus.out_last !== 1'b1) $display("FAIL stall_b2: got %h/%b want %h/1", bus.out_data, bus.out_last, e2); else n_pass++;
    idle();
    step();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL stall_drain: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_drop();
    for (int i = 0; i < 5; i++) begin
      drive(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
      step();
      n_total++; if (bus.out_valid !== 1'b0) $display("FAIL drop_valid_%0d: got %b want 0", i, bus.out_valid); else n_pass++;
    end
    n_total++; if (drop_cnt !== 16'd5) $display("FAIL drop_cnt5: got %0d want 5", drop_cnt); else n_pass++;
    cfg_seed = SEED_V;
    drive(8'h00, 1'b1, 1'b1, 1'b0);
    step();
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hF9 || bus.out_last !== 1'b1) $display("FAIL single_beat: got %b/%h/%b want 1/f9/1", bus.out_valid, bus.out_data, bus.out_last); else n_pass++;
    drive(8'h77, 1'b0, 1'b0, 1'b0);
    step();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL single_idle_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (drop_cnt !== 16'd6) $display("FAIL single_idle_drop: got %0d want 6", drop_cnt); else n_pass++;
    idle();
    step();
  endtask

  task automatic test_err();
    logic [7:0] e1, e2;
    e1 = 8'h55 ^ ks_byte(15'h4ACE, 0);
    e2 = ks_byte(15'h4ACE, 1);
    cfg_seed = SEED_V;
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    step();
    n_total++; if (bus.out_data !== 8'hF9 || err_no_last !== 1'b0) $display("FAIL err_b0: got %h/%b want f9/0", bus.out_data, err_no_last); else n_pass++;
    cfg_seed = 15'h4ACE;
    drive(8'h55, 1'b1, 1'b0, 1'b0);
    step();
    n_total++; if (err_no_last !== 1'b1) $display("FAIL err_flag: got %b want 1", err_no_last); else n_pass++;
    n_total++; if (bus.out_data !== e1) $display("FAIL err_reseed_b0: got %h want %h", bus.out_data, e1); else n_pass++;
    drive(8'h00, 1'b0, 1'b1, 1'b0);
    step();
    n_total++; if (bus.out_data !== e2 || bus.out_last !== 1'b1) $display("FAIL err_reseed_b1: got %h/%b want %h/1", bus.out_data, bus.out_last, e2); else n_pass++;
    idle();
    step();
    n_total++; if (err_no_last !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_no_last); else n_pass++;
  endtask

  task automatic test_reset_mid();
    cfg_seed = SEED_V;
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    #2 reset = 1'b0;
    #1;
    n_total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_last !== 1'b0) $display("FAIL rstmid_out: got %b/%h/%b want 0/00/0", bus.out_valid, bus.out_data, bus.out_last); else n_pass++;
    n_total++; if (err_no_last !== 1'b0 || drop_cnt !== 16'd0) $display("FAIL rstmid_status: got %b/%0d want 0/0", err_no_last, drop_cnt); else n_pass++;
    #2 reset = 1'b1;
    drive(8'h12, 1'b0, 1'b0, 1'b0);
    step();
    n_total++; if (bus.out_valid !== 1'b0 || drop_cnt !== 16'd1) $display("FAIL rstmid_needs_first: got %b/%0d want 0/1", bus.out_valid, drop_cnt); else n_pass++;
    idle();
    step();
  endtask

  task automatic test_bypass();
    cfg_seed = SEED_V;
    drive(8'h00, 1'b1, 1'b0, 1'b0);
    step();
    n_total++; if (bus.out_data !== 8'hF9) $display("FAIL bypass_b0: got %h want f9", bus.out_data); else n_pass++;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    step();
    n_total++; if (bus.out_data !== 8'h00 || bus.out_valid !== 1'b1) $display("FAIL bypass_b1: got %b/%h want 1/00", bus.out_valid, bus.out_data); else n_pass++;
    drive(8'h00, 1'b0, 1'b1, 1'b0);
    step();
    n_total++; if (bus.out_data !== 8'h36 || bus.out_last !== 1'b1) $display("FAIL bypass_b2: got %h/%b want 36/1", bus.out_data, bus.out_last); else n_pass++;
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reseed();
    test_stall();
    test_drop();
    test_err();
    test_reset_mid();
    test_bypass();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
